// File: rtl/wii_classic_target.sv
// I2C target emulating a Wii Classic Controller extension (unencrypted report).
// Serves a 6-byte report from an 8-bit register pointer and ACKs init writes.
module wii_classic_target #(
  parameter logic [6:0] I2C_ADDR  = 7'h52,
  parameter int         NUM_BYTES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] udlr_dpad,
  input  logic [3:0] abxy_btns,
  input  logic [4:0] l_trig_btn,
  input  logic [4:0] r_trig_btn,
  input  logic [1:0] lr_z_btns,
  input  logic [2:0] st_sel_hm_btns,
  input  logic [5:0] l_stick_x,
  input  logic [5:0] l_stick_y,
  input  logic [4:0] r_stick_x,
  input  logic [4:0] r_stick_y,
  inout  wire        sda,
  inout  wire        scl,
  output logic       busy,
  output logic       rd_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WR_BYTE   = 3'd3;
  localparam logic [2:0] S_WR_ACK    = 3'd4;
  localparam logic [2:0] S_RD_BYTE   = 3'd5;
  localparam logic [2:0] S_RD_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  localparam int         REPORT_LEN = 6;
  localparam int         VALID_LEN  = (NUM_BYTES < REPORT_LEN) ? NUM_BYTES : REPORT_LEN;
  localparam logic [7:0] VALID_LIM  = 8'(VALID_LEN);

  logic       r_scl_m, r_scl_s, r_scl_d;
  logic       r_sda_m, r_sda_s, r_sda_d;
  logic [2:0] r_state;
  logic [2:0] r_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_first;
  logic       r_phase;
  logic       r_oe;
  logic       r_busy;
  logic       r_rd_done;
  logic [7:0] r_snap [0:REPORT_LEN-1];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_report [0:REPORT_LEN-1];
  logic [7:0] w_rd_byte;
  logic [7:0] w_rx_byte;

  assign sda     = r_oe ? 1'b0 : 1'bz;
  assign scl     = 1'bz;
  assign busy    = r_busy;
  assign rd_done = r_rd_done;

  assign w_scl_rise = r_scl_s & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s & r_scl_d;
  assign w_start    = r_scl_s & r_scl_d & ~r_sda_s & r_sda_d;
  assign w_stop     = r_scl_s & r_scl_d & r_sda_s & ~r_sda_d;
  assign w_rx_byte  = {r_shift, r_sda_s};

  // Buttons are active-low on the bus; bits fixed at 1 are unused report slots.
  always_comb begin
    w_report[0] = {r_stick_x[4:3], l_stick_x};
    w_report[1] = {r_stick_x[2:1], l_stick_y};
    w_report[2] = {r_stick_x[0], l_trig_btn[4:3], r_stick_y};
    w_report[3] = {l_trig_btn[2:0], r_trig_btn};
    w_report[4] = {~udlr_dpad[0], ~udlr_dpad[2], 1'b1, ~st_sel_hm_btns[1],
                   ~st_sel_hm_btns[0], ~st_sel_hm_btns[2], 2'b11};
    w_report[5] = {~lr_z_btns[1], ~abxy_btns[2], ~abxy_btns[0], ~abxy_btns[3],
                   ~abxy_btns[1], ~lr_z_btns[0], ~udlr_dpad[1], ~udlr_dpad[3]};
  end

  always_comb begin
    w_rd_byte = 8'hFF;
    if (r_ptr < VALID_LIM) w_rd_byte = r_snap[r_ptr[2:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {r_scl_m, r_scl_s, r_scl_d} <= '1;
      {r_sda_m, r_sda_s, r_sda_d} <= '1;
    end else begin
      r_scl_m <= scl;
      r_scl_s <= r_scl_m;
      r_scl_d <= r_scl_s;
      r_sda_m <= sda;
      r_sda_s <= r_sda_m;
      r_sda_d <= r_sda_s;
    end
  end

  // ACK states use r_phase: the first scl fall opens the ACK slot, the fall
  // after the 9th rise closes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
      r_phase   <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_done <= 1'b0;
      for (int unsigned i = 0; i < REPORT_LEN; i++) r_snap[i] <= '0;
    end else begin
      r_rd_done <= 1'b0;
      if (w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= '0;
        r_phase <= 1'b0;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_oe <= 1'b0;
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte[6:0];
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_phase <= 1'b0;
                r_rw    <= r_sda_s;
                if (r_shift == I2C_ADDR && r_shift != 7'd0) r_state <= S_ADDR_ACK;
                else r_state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_oe   <= 1'b1;
                r_busy <= 1'b1;
                if (r_rw) r_snap <= w_report;
              end else begin
                r_cnt <= '0;
                if (r_rw) begin
                  r_state <= S_RD_BYTE;
                  r_shift <= w_rd_byte[6:0];
                  r_oe    <= ~w_rd_byte[7];
                end else begin
                  r_state <= S_WR_BYTE;
                  r_first <= 1'b1;
                  r_oe    <= 1'b0;
                end
              end
            end else if (w_scl_rise) begin
              r_phase <= 1'b1;
            end
          end
          S_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte[6:0];
              r_cnt   <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_state <= S_WR_ACK;
                r_phase <= 1'b0;
                r_first <= 1'b0;
                if (r_first) r_ptr <= w_rx_byte;
                else r_ptr <= r_ptr + 8'd1;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_oe <= 1'b1;
              end else begin
                r_oe    <= 1'b0;
                r_state <= S_WR_BYTE;
                r_cnt   <= '0;
              end
            end else if (w_scl_rise) begin
              r_phase <= 1'b1;
            end
          end
          S_RD_BYTE: begin
            if (w_scl_fall) begin
              r_oe    <= ~r_shift[6];
              r_shift <= {r_shift[5:0], 1'b1};
            end else if (w_scl_rise) begin
              r_cnt <= r_cnt + 3'd1;
              if (r_cnt == 3'd7) begin
                r_state <= S_RD_ACK;
                r_phase <= 1'b0;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_oe <= 1'b0;
              end else begin
                r_state <= S_RD_BYTE;
                r_cnt   <= '0;
                r_shift <= w_rd_byte[6:0];
                r_oe    <= ~w_rd_byte[7];
              end
            end else if (w_scl_rise) begin
              r_phase <= 1'b1;
              if (r_sda_s) begin
                r_rd_done <= 1'b1;
                r_state   <= S_WAIT_STOP;
              end else begin
                r_ptr <= r_ptr + 8'd1;
              end
            end
          end
          S_WAIT_STOP: r_oe <= 1'b0;
          default: begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wii_classic_target.sv
// Bench for wii_classic_target: bit-banged I2C host plus a report/pointer model.
module tb_wii_classic_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] udlr_dpad, abxy_btns;
  logic [4:0] l_trig_btn, r_trig_btn, r_stick_x, r_stick_y;
  logic [5:0] l_stick_x, l_stick_y;
  logic [1:0] lr_z_btns;
  logic [2:0] st_sel_hm_btns;
  logic       busy, rd_done;
  logic       host_sda_low = 1'b0;
  logic       host_scl_low = 1'b0;
  wire        sda, scl;

  int n_cmp = 0;
  int n_err = 0;
  int tgt_low_cnt = 0;
  int rd_cnt = 0, rd_run = 0, rd_max = 0;

  logic [7:0] snap [6];
  logic [7:0] m_ptr = 8'h00;

  always #5 clk = ~clk;

  assign sda = host_sda_low ? 1'b0 : 1'bz;
  assign scl = host_scl_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  wii_classic_target #(.I2C_ADDR(7'h52), .NUM_BYTES(6)) dut (
    .clk(clk), .reset(reset),
    .udlr_dpad(udlr_dpad), .abxy_btns(abxy_btns),
    .l_trig_btn(l_trig_btn), .r_trig_btn(r_trig_btn),
    .lr_z_btns(lr_z_btns), .st_sel_hm_btns(st_sel_hm_btns),
    .l_stick_x(l_stick_x), .l_stick_y(l_stick_y),
    .r_stick_x(r_stick_x), .r_stick_y(r_stick_y),
    .sda(sda), .scl(scl), .busy(busy), .rd_done(rd_done)
  );

  always @(posedge clk) begin
    if (!host_sda_low && sda === 1'b0) tgt_low_cnt++;
    if (rd_done === 1'b1) begin
      rd_cnt++;
      rd_run++;
      if (rd_run > rd_max) rd_max = rd_run;
    end else begin
      rd_run = 0;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached (actual running, required finished)");
    $fatal(1);
  end

  // Reference report built from named controls; buttons are 0 = pressed on the bus.
  function automatic logic [7:0] report_byte(input int idx);
    logic up, down, left, right, a, b, x, y, st, sel, hm;
    {up, down, left, right} = udlr_dpad;
    {a, b, x, y}            = abxy_btns;
    {st, sel, hm}           = st_sel_hm_btns;
    case (idx)
      0: return {r_stick_x[4:3], l_stick_x};
      1: return {r_stick_x[2:1], l_stick_y};
      2: return {r_stick_x[0], l_trig_btn[4:3], r_stick_y};
      3: return {l_trig_btn[2:0], r_trig_btn};
      4: return {!right, !down, 1'b1, !sel, !hm, !st, 1'b1, 1'b1};
      5: return {!lr_z_btns[1], !b, !y, !a, !x, !lr_z_btns[0], !left, !up};
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] expect_at(input logic [7:0] p);
    return (p < 8'd6) ? snap[p[2:0]] : 8'hFF;
  endfunction

  task automatic take_snapshot();
    for (int i = 0; i < 6; i++) snap[i] = report_byte(i);
  endtask

  task automatic rand_inputs();
    udlr_dpad = 4'($urandom); abxy_btns = 4'($urandom);
    l_trig_btn = 5'($urandom); r_trig_btn = 5'($urandom);
    r_stick_x = 5'($urandom); r_stick_y = 5'($urandom);
    l_stick_x = 6'($urandom); l_stick_y = 6'($urandom);
    lr_z_btns = 2'($urandom); st_sel_hm_btns = 3'($urandom);
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic r);
    host_sda_low = ~b;
    qwait();
    host_scl_low = 1'b0;
    qwait();
    r = sda;
    qwait();
    host_scl_low = 1'b1;
    qwait();
  endtask

  task automatic i2c_start();
    if (host_scl_low) begin
      host_sda_low = 1'b0;
      qwait();
      host_scl_low = 1'b0;
      qwait();
    end
    host_sda_low = 1'b1;
    qwait();
    host_scl_low = 1'b1;
    qwait();
  endtask

  task automatic i2c_stop();
    host_sda_low = 1'b1;
    qwait();
    host_scl_low = 1'b0;
    qwait();
    host_sda_low = 1'b0;
    qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(nack, r);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rd_done !== 1'b0) begin n_err++; $display("FAIL reset_rd_done: got %b want 0", rd_done); end
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (tgt_low_cnt !== 0) begin n_err++; $display("FAIL reset_idle_sda: low cycles %0d want 0", tgt_low_cnt); end
    m_ptr = 8'h00;
  endtask

  task automatic test_pointer_write();
    logic a0, a1;
    i2c_start();
    send_byte(8'hA4, a0);
    n_cmp++; if (a0 !== 1'b0) begin n_err++; $display("FAIL wr_addr_ack: got %b want 0", a0); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_after_ack: got %b want 1", busy); end
    send_byte(8'h00, a1);
    n_cmp++; if (a1 !== 1'b0) begin n_err++; $display("FAIL wr_data_ack: got %b want 0", a1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_before_stop: got %b want 1", busy); end
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    m_ptr = 8'h00;
  endtask

  task automatic test_report_read();
    logic a;
    logic [7:0] d;
    logic [7:0] want [6] = '{8'hAA, 8'h55, 8'hEC, 8'hE5, 8'hFF, 8'hFE};
    int rd0;
    l_stick_x = 6'h2A; l_stick_y = 6'h15; r_stick_x = 5'h13; r_stick_y = 5'h0C;
    l_trig_btn = 5'h1F; r_trig_btn = 5'h05;
    udlr_dpad = 4'b1000; abxy_btns = '0; lr_z_btns = '0; st_sel_hm_btns = '0;
    rd0 = rd_cnt;
    rd_max = 0;
    i2c_start();
    send_byte(8'hA5, a);
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rd_addr_ack: got %b want 0", a); end
    for (int k = 0; k < 6; k++) begin
      recv_byte(k == 5, d);
      if (k == 0) rand_inputs();
      n_cmp++; if (d !== want[k]) begin n_err++; $display("FAIL rd_byte%0d: got %h want %h", k, d, want[k]); end
    end
    i2c_stop();
    n_cmp++; if (rd_cnt - rd0 !== 1) begin n_err++; $display("FAIL rd_done_count: got %0d want 1", rd_cnt - rd0); end
    n_cmp++; if (rd_max !== 1) begin n_err++; $display("FAIL rd_done_width: got %0d want 1", rd_max); end
    m_ptr = 8'h05;
  endtask

  task automatic test_addr_miss();
    logic a0, a1, a2;
    int low0;
    low0 = tgt_low_cnt;
    i2c_start();
    send_byte(8'hA6, a0);
    send_byte(8'hA4, a1);
    send_byte(8'h00, a2);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL miss_busy: got %b want 0", busy); end
    i2c_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL miss_acks: got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (tgt_low_cnt !== low0) begin n_err++; $display("FAIL miss_sda_low: got %0d low cycles want 0", tgt_low_cnt - low0); end
    i2c_start();
    send_byte(8'h00, a0);
    i2c_stop();
    n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL general_call_ack: got %b want 1", a0); end
  endtask

  task automatic test_oor_repeated_start();
    logic a0, a1, a2;
    logic [7:0] d;
    rand_inputs();
    i2c_start();
    send_byte(8'hA4, a0);
    send_byte(8'h04, a1);
    i2c_start();
    send_byte(8'hA5, a2);
    take_snapshot();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); end
    m_ptr = 8'h04;
    for (int k = 0; k < 3; k++) begin
      recv_byte(k == 2, d);
      n_cmp++; if (d !== expect_at(m_ptr)) begin n_err++; $display("FAIL rs_byte%0d: got %h want %h", k, d, expect_at(m_ptr)); end
      if (k != 2) m_ptr++;
    end
    i2c_stop();
    i2c_start();
    send_byte(8'hA4, a0);
    send_byte(8'hF0, a1);
    send_byte(8'h55, a2);
    i2c_stop();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL init_acks: got %b want 000", {a0, a1, a2}); end
    m_ptr = 8'hF1;
  endtask

  task automatic test_pointer_wrap();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA4, a0);
    send_byte(8'hFE, a1);
    i2c_stop();
    i2c_start();
    send_byte(8'hA5, a2);
    take_snapshot();
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL wrap_acks: got %b want 000", {a0, a1, a2}); end
    m_ptr = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      recv_byte(k == 2, d);
      n_cmp++; if (d !== expect_at(m_ptr)) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", k, d, expect_at(m_ptr)); end
      if (k != 2) m_ptr++;
    end
    i2c_stop();
    rand_inputs();
    i2c_start();
    send_byte(8'hA5, a0);
    take_snapshot();
    recv_byte(1'b1, d);
    i2c_stop();
    n_cmp++; if (d !== expect_at(m_ptr)) begin n_err++; $display("FAIL kept_ptr: got %h want %h", d, expect_at(m_ptr)); end
  endtask

  task automatic test_random();
    logic a0, a1, a2;
    logic [7:0] d, p;
    int n;
    for (int it = 0; it < 6; it++) begin
      rand_inputs();
      p = 8'($urandom_range(0, 7));
      n = $urandom_range(1, 4);
      i2c_start();
      send_byte(8'hA4, a0);
      send_byte(p, a1);
      if ($urandom_range(0, 1) == 1) i2c_stop();
      i2c_start();
      send_byte(8'hA5, a2);
      take_snapshot();
      m_ptr = p;
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rnd%0d_acks: got %b want 000", it, {a0, a1, a2}); end
      for (int k = 0; k < n; k++) begin
        recv_byte(k == n - 1, d);
        if ($urandom_range(0, 1) == 1) rand_inputs();
        n_cmp++; if (d !== expect_at(m_ptr)) begin n_err++; $display("FAIL rnd%0d_byte%0d: got %h want %h", it, k, d, expect_at(m_ptr)); end
        if (k != n - 1) m_ptr++;
      end
      i2c_stop();
    end
  endtask

  task automatic test_reset_mid_read();
    logic a, r;
    logic [7:0] d;
    int low0;
    rand_inputs();
    r_stick_x[4] = 1'b0;
    i2c_start();
    send_byte(8'hA4, a);
    send_byte(8'h00, a);
    i2c_start();
    send_byte(8'hA5, a);
    n_cmp++; if (sda !== 1'b0) begin n_err++; $display("FAIL mid_tgt_drive: got %b want 0", sda); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL mid_reset_sda: got %b want 1 (released)", sda); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_ptr = 8'h00;
    low0 = tgt_low_cnt;
    for (int i = 0; i < 9; i++) clock_bit(1'b1, r);
    n_cmp++; if (tgt_low_cnt !== low0) begin n_err++; $display("FAIL mid_idle_sda: got %0d low cycles want 0", tgt_low_cnt - low0); end
    i2c_stop();
    rand_inputs();
    i2c_start();
    send_byte(8'hA5, a);
    take_snapshot();
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL post_reset_ack: got %b want 0", a); end
    for (int k = 0; k < 2; k++) begin
      recv_byte(k == 1, d);
      n_cmp++; if (d !== expect_at(m_ptr)) begin n_err++; $display("FAIL post_reset_byte%0d: got %h want %h", k, d, expect_at(m_ptr)); end
      if (k != 1) m_ptr++;
    end
    i2c_stop();
  endtask

  initial begin
    reset = 1'b0;
    rand_inputs();
    #1;
    test_reset();
    test_pointer_write();
    test_report_read();
    test_addr_miss();
    test_oor_repeated_start();
    test_pointer_wrap();
    test_random();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wii_classic_target.md
Name: wii_classic_target

Overview:
- I2C target (slave) that emulates a Wii Classic Controller extension at 7-bit address 0x52.
- Lets the team's PicoBlaze I2C controller-reader, or a real Wii host, be driven from FPGA-side button and stick values. Used for loopback test and controller passthrough.
- Serves the standard 6-byte report from a register pointer. Accepts init writes (0xF0=0x55, 0xFB=0x00) and ACKs them.
- Unencrypted mode only; no clock stretching.

Parameters:
- I2C_ADDR, 7'h52, target address matched on the bus.
- NUM_BYTES, 6, number of report bytes mapped at pointer 0..NUM_BYTES-1.

Ports:
- clk  input  1  system clock, must be at least 16x the SCL frequency.
- reset  input  1  synchronous, active-low reset.
- udlr_dpad  input  4  {up,down,left,right}, 1 = pressed.
- abxy_btns  input  4  {a,b,x,y}, 1 = pressed.
- l_trig_btn  input  5  left trigger analog.
- r_trig_btn  input  5  right trigger analog.
- lr_z_btns  input  2  Z buttons, 1 = pressed.
- st_sel_hm_btns  input  3  {start,select,home}, 1 = pressed.
- l_stick_x, l_stick_y  input  6 each  left stick.
- r_stick_x, r_stick_y  input  5 each  right stick.
- sda  inout  1  open-drain data: drives 0 or z, never 1.
- scl  inout  1  input only; the block never drives it (z).
- busy  output  1  high from own-address ACK until STOP/START.
- rd_done  output  1  1-cycle pulse when the host NACKs a read byte.

Behaviour:
- Reset (reset==0 at posedge): sda released; busy=0; rd_done=0; state IDLE; pointer=0; shifter cleared.
  - Applies mid-transfer: sda is released the cycle after reset.
- Input sync: scl and sda each pass through a 2-FF synchronizer, then a 1-FF edge register.
- Bus events (from synced signals):
  - START: sda falls while scl=1.
  - STOP: sda rises while scl=1.
  - Data is sampled on scl rising edges.
  - The sda driver updates only on scl falling edges, at most 4 clk after the pad edge.
- Report encoding (buttons inverted on the bus, 0 = pressed):
  - B0 = {rx[4:3], lx}
  - B1 = {rx[2:1], ly}
  - B2 = {rx[0], lt[4:3], ry}
  - B3 = {lt[2:0], rt}
  - B4 = {~right, ~down, 1, ~select, ~home, ~start, 1, 1}
  - B5 = {~lr_z[1], ~b, ~y, ~a, ~x, ~lr_z[0], ~left, ~up}
- Snapshot: all 6 bytes are latched together in the cycle the read-address ACK starts, so the whole report is coherent.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits, MSB first.
    - Address match: go to ADDR_ACK and pull sda low for the 9th clock. busy=1.
    - Mismatch: go to WAIT_STOP with sda released.
  - R/W=0: ADDR_ACK -> WR_BYTE.
    - First data byte loads pointer. Later bytes are discarded and pointer increments.
    - Every byte is ACKed (WR_ACK).
  - R/W=1: ADDR_ACK -> RD_BYTE.
    - Shift out byte[pointer] MSB first. Pointer >= NUM_BYTES returns 0xFF.
    - Release sda during RD_ACK and sample the host bit on scl rise.
    - Host ACK (0): pointer+1, next byte.
    - Host NACK (1): rd_done pulse, go to WAIT_STOP.
  - Pointer is 8 bits and wraps 0xFF -> 0x00.
  - WAIT_STOP: sda released; exits only on START or STOP.
- START in any state, including mid-byte (repeated start): abort the byte, release sda, go to ADDR. Pointer is kept.
- STOP in any state: release sda, busy=0, go to IDLE. Pointer is kept.
- Simultaneous START/STOP detection is impossible (single sda edge). A scl edge coincident with a START is ignored.
- A general call (address 0x00) is not ACKed.

Test Plan:
- Reset: hold reset=0 for 3 cycles with the bus idle-high -> sda=z, busy=0, rd_done=0. Release reset; bus stays untouched.
- Pointer write: START, 0xA4, 0x00, STOP -> target ACKs the 9th bit of both bytes, busy high between the ACK and STOP, pointer=0.
- Report read: inputs lx=0x2A, ly=0x15, rx=0x13, ry=0x0C, lt=0x1F, rt=0x05, only up pressed. START, 0xA5, read 6 bytes, host ACKs 5 and NACKs the 6th.
  - Expect bytes 0xAA, 0x55, 0xEC, 0xE5, 0xFF, 0xFE.
  - rd_done pulses once.
  - Changing the inputs mid-read does not alter the bytes.
- Address miss: START, 0xA6 (addr 0x53) -> sda never low. Following bytes are ignored until STOP.
- Out-of-range and repeated start: write pointer 0x04, repeated START, 0xA5, read 3 bytes -> B4, B5, 0xFF. Then init write 0xA4, 0xF0, 0x55 -> all ACKed.
- Reset mid-read: assert reset while the target drives a 0 data bit -> sda=z on the next clk, FSM in IDLE. The next full transaction succeeds.
